// File: rtl/ct_f_spsram_init.sv
// ct_f_spsram_init: single-port SRAM model with per-bit write mask and a
// clear-on-reset sweep that writes INIT_DATA to every word before user access.
// Optional feature macro: CT_F_SPSRAM_OUTREG_EN adds a second output register
// stage (2-cycle read latency); default build has a 1-cycle read latency.
module ct_f_spsram_init #(
   parameter int                    ADDR_WIDTH = 12,
   parameter int                    DATA_WIDTH = 144,
   parameter logic [DATA_WIDTH-1:0] INIT_DATA  = {DATA_WIDTH{1'b0}}
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic                  CEN,
   input  logic [DATA_WIDTH-1:0] D,
   input  logic                  GWEN,
   input  logic [DATA_WIDTH-1:0] WEN,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  INIT_BUSY
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {ST_INIT, ST_IDLE} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] arr_q;

   logic                  acc;
   logic [DATA_WIDTH-1:0] wmask;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] acc_word;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // Sweep sequencing: count up through every address, leave INIT after the last one
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         if (cnt_q == '1) state_d = ST_IDLE;
         else             cnt_d   = cnt_q + 1'b1;
      end
   end

   // Array port muxing: sweep owns the array in INIT, user port in IDLE.
   // A read is a masked write with an empty mask, so one merged word serves
   // both the write data and the write-first read result.
   always_comb begin
      acc       = (state_q == ST_IDLE) && !CEN;
      wmask     = GWEN ? '0 : ~WEN;
      rd_word   = mem_q[A];
      acc_word  = (D & wmask) | (rd_word & ~wmask);
      mem_we    = !RST && ((state_q == ST_INIT) || (acc && !GWEN));
      mem_addr  = (state_q == ST_INIT) ? cnt_q : A;
      mem_wdata = (state_q == ST_INIT) ? INIT_DATA : acc_word;
   end

   // FSM state and sweep counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Array-output register: loads only on a user access, otherwise holds
   always_ff @(posedge CLK) begin
      if (RST)      arr_q <= '0;
      else if (acc) arr_q <= acc_word;
   end

   // Storage array, no reset so it maps onto RAM resources
   always_ff @(posedge CLK) begin
      if (mem_we) mem_q[mem_addr] <= mem_wdata;
   end

   assign INIT_BUSY = (state_q == ST_INIT);

`ifdef CT_F_SPSRAM_OUTREG_EN
   logic [DATA_WIDTH-1:0] out_q;

   // Second output stage: frozen during the sweep, follows arr_q every IDLE edge
   always_ff @(posedge CLK) begin
      if (RST)                     out_q <= '0;
      else if (state_q == ST_IDLE) out_q <= arr_q;
   end

   assign Q = out_q;
`else
   assign Q = arr_q;
`endif

endmodule

// File: tb/tb_ct_f_spsram_init.sv
// Testbench for ct_f_spsram_init: randomized accesses checked against a
// behavioural memory model; honours CT_F_SPSRAM_OUTREG_EN for latency.
module tb_ct_f_spsram_init;

   localparam int AW    = 4;
   localparam int DW    = 144;
   localparam int DEPTH = 1 << AW;
   localparam logic [DW-1:0] INIT = {18{8'hA5}};
`ifdef CT_F_SPSRAM_OUTREG_EN
   localparam bit OUTREG = 1'b1;
`else
   localparam bit OUTREG = 1'b0;
`endif

   logic          CLK;
   logic          RST;
   logic [AW-1:0] A;
   logic          CEN;
   logic [DW-1:0] D;
   logic          GWEN;
   logic [DW-1:0] WEN;
   logic [DW-1:0] Q;
   logic          INIT_BUSY;

   int nchk = 0;
   int nerr = 0;

   // model: remaining sweep edges, memory contents, read register(s)
   int            m_left = 0;
   logic [DW-1:0] m_mem [DEPTH];
   logic [DW-1:0] m_q  = '0;
   logic [DW-1:0] m_q2 = '0;

   ct_f_spsram_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_DATA(INIT)) dut (
      .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .D(D), .GWEN(GWEN),
      .WEN(WEN), .Q(Q), .INIT_BUSY(INIT_BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] rnd();
      logic [159:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] exp_q();
      return OUTREG ? m_q2 : m_q;
   endfunction

   function automatic logic exp_busy();
      return m_left > 0;
   endfunction

   // one clock edge: drive inputs, advance the model, settle past the edge
   task automatic step(input logic rst, input logic cen, input logic gwen,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] wen);
      RST = rst; CEN = cen; GWEN = gwen; A = a; D = d; WEN = wen;
      @(posedge CLK);
      if (rst) begin
         m_left = DEPTH; m_q = '0; m_q2 = '0;
      end else if (m_left > 0) begin
         m_mem[DEPTH - m_left] = INIT;
         m_left--;
      end else begin
         m_q2 = m_q;
         if (!cen) begin
            for (int i = 0; i < DW; i++)
               if (!gwen && !wen[i]) m_mem[a][i] = d[i];
            m_q = m_mem[a];
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, AW'($urandom()), rnd(), rnd());
   endtask

   task automatic rd(input logic [AW-1:0] a);
      step(1'b0, 1'b0, 1'b1, a, rnd(), rnd());
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] wen);
      step(1'b0, 1'b0, 1'b0, a, d, wen);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, AW'(i), '1, '0);
         nchk++;
         if (INIT_BUSY !== 1'b1) begin nerr++; $display("FAIL reset_busy got %b want 1", INIT_BUSY); end
         nchk++;
         if (Q !== '0) begin nerr++; $display("FAIL reset_q got %h want 0", Q); end
      end
   endtask

   // user write to address 5 held through the whole sweep must be ignored
   task automatic test_sweep_user_access();
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b0, 1'b0, AW'(5), '1, '0);
         nchk++;
         if (INIT_BUSY !== (i < DEPTH - 1)) begin
            nerr++; $display("FAIL sweep_busy edge %0d got %b want %b", i, INIT_BUSY, i < DEPTH - 1);
         end
         nchk++;
         if (Q !== '0) begin nerr++; $display("FAIL sweep_q edge %0d got %h want 0", i, Q); end
      end
      for (int a = 0; a < DEPTH; a++) begin
         rd(AW'(a));
         idle(1);
         nchk++;
         if (Q !== INIT) begin nerr++; $display("FAIL sweep_read addr %0d got %h want %h", a, Q, INIT); end
      end
   endtask

   task automatic test_masked_write();
      logic [DW-1:0] lo8;
      lo8 = '0; lo8[7:0] = 8'hFF;
      wr(AW'(3), '0, '0);
      wr(AW'(3), '1, ~lo8);
      nchk++;
      if (Q !== exp_q()) begin nerr++; $display("FAIL mask_edge got %h want %h", Q, exp_q()); end
      idle(1);
      nchk++;
      if (Q !== lo8) begin nerr++; $display("FAIL mask_q got %h want %h", Q, lo8); end
      rd(AW'(3));
      idle(1);
      nchk++;
      if (Q !== lo8) begin nerr++; $display("FAIL mask_reread got %h want %h", Q, lo8); end
   endtask

   task automatic test_hold_latency();
      logic [DW-1:0] x, y;
      x = rnd(); y = ~x;
      wr(AW'(2), x, '0);
      wr(AW'(7), y, '0);
      idle(1);
      rd(AW'(2));
      nchk++;
      if (Q !== (OUTREG ? y : x)) begin
         nerr++; $display("FAIL lat_first got %h want %h", Q, OUTREG ? y : x);
      end
      for (int k = 1; k <= 5; k++) begin
         idle(1);
         nchk++;
         if (Q !== x) begin nerr++; $display("FAIL hold cycle %0d got %h want %h", k, Q, x); end
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] wen;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 3))
            0:       wen = '1;
            1:       wen = '0;
            default: wen = rnd();
         endcase
         step(1'b0, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
              AW'($urandom()), rnd(), wen);
         nchk++;
         if (Q !== exp_q() || INIT_BUSY !== exp_busy()) begin
            nerr++;
            $display("FAIL random op %0d q %h busy %b want q %h busy %b", n, Q, INIT_BUSY, exp_q(), exp_busy());
         end
      end
   endtask

   task automatic test_mid_sweep_reset();
      int n;
      logic [AW-1:0] a;
      step(1'b1, 1'b1, 1'b1, '0, '0, '1);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, AW'($urandom()), rnd(), rnd());
      step(1'b1, 1'b1, 1'b1, '0, '0, '1);
      n = 0;
      while (INIT_BUSY === 1'b1 && n < 40) begin
         step(1'b0, 1'b0, $urandom_range(0, 1) == 1, AW'($urandom()), rnd(), rnd());
         n++;
      end
      nchk++;
      if (n != DEPTH) begin nerr++; $display("FAIL midreset_len got %0d want %0d", n, DEPTH); end
      nchk++;
      if (Q !== '0) begin nerr++; $display("FAIL midreset_q got %h want 0", Q); end
      a = AW'($urandom());
      rd(a);
      idle(1);
      nchk++;
      if (Q !== INIT) begin nerr++; $display("FAIL midreset_read addr %0d got %h want %h", a, Q, INIT); end
   endtask

   task automatic test_collision();
      logic [DW-1:0] d;
      d = '0; d[15:0] = 16'h1234;
      wr(AW'(0), rnd(), '0);
      step(1'b1, 1'b0, 1'b0, AW'(0), d, '0);
      nchk++;
      if (Q !== '0 || INIT_BUSY !== 1'b1) begin
         nerr++; $display("FAIL collide_edge q %h busy %b want q 0 busy 1", Q, INIT_BUSY);
      end
      idle(DEPTH);
      nchk++;
      if (INIT_BUSY !== 1'b0) begin nerr++; $display("FAIL collide_busy got %b want 0", INIT_BUSY); end
      rd(AW'(0));
      idle(1);
      nchk++;
      if (Q !== INIT) begin nerr++; $display("FAIL collide_read got %h want %h", Q, INIT); end
   endtask

   initial begin
      RST = 1'b1; CEN = 1'b1; GWEN = 1'b1; A = '0; D = '0; WEN = '1;
      test_reset();
      test_sweep_user_access();
      test_masked_write();
      test_hold_latency();
      test_random();
      test_mid_sweep_reset();
      test_collision();
      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule
